// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute FSM with a small return-address stack.
// Branch, call, return and halt resolve in EXEC with priority halt > ret > call > taken branch.
module pc_sequencer #(
  parameter int PSIZE     = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ack,
  input  logic             stall,
  input  logic             op_branch,
  input  logic             cond,
  input  logic             op_call,
  input  logic             op_ret,
  input  logic             op_halt,
  input  logic             resume,
  input  logic [PSIZE-1:0] branch_target,
  output logic             imem_req,
  output logic [PSIZE-1:0] pc_out,
  output logic             ir_load,
  output logic             exec_en,
  output logic             halted,
  output logic             ras_ovf,
  output logic             ras_unf
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t           state_q, state_d;
  logic [PSIZE-1:0] pc_q, pc_d, pc_inc;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_m1;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push;
  logic [PSIZE-1:0] ras_q [RAS_DEPTH];

  assign pc_inc = pc_q + 1'b1;
  assign cnt_m1 = cnt_q - 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ack) state_d = EXEC;
      EXEC: begin
        // Decode inputs only matter on the single completing cycle.
        if (!stall) begin
          state_d = FETCH;
          if (op_halt) begin
            pc_d    = pc_inc;
            state_d = HALT;
          end else if (op_ret) begin
            if (cnt_q != '0) begin
              pc_d  = ras_q[cnt_m1[AW-1:0]];
              cnt_d = cnt_m1;
            end else begin
              pc_d  = pc_inc;
              unf_d = 1'b1;
            end
          end else if (op_call) begin
            pc_d = branch_target;
            if (cnt_q == CW'(RAS_DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              push  = 1'b1;
              cnt_d = cnt_q + 1'b1;
            end
          end else if (op_branch && cond) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      HALT:    if (resume) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push) ras_q[cnt_q[AW-1:0]] <= pc_inc;
    end
  end

  assign imem_req = (state_q == FETCH);
  assign ir_load  = (state_q == FETCH) && imem_ack;
  assign exec_en  = (state_q == EXEC) && !stall;
  assign halted   = (state_q == HALT);
  assign pc_out   = pc_q;
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: stimulus queues the expected pc/flags for each fetch; a monitor
// checks them whenever the DUT strobes ir_load.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       imem_ack = 1'b0, stall = 1'b0, op_branch = 1'b0, cond = 1'b0;
  logic       op_call = 1'b0, op_ret = 1'b0, op_halt = 1'b0, resume = 1'b0;
  logic [4:0] branch_target = '0;
  logic       imem_req, ir_load, exec_en, halted, ras_ovf, ras_unf;
  logic [4:0] pc_out;

  pc_sequencer #(.PSIZE(5), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .imem_ack(imem_ack), .stall(stall),
    .op_branch(op_branch), .cond(cond), .op_call(op_call), .op_ret(op_ret),
    .op_halt(op_halt), .resume(resume), .branch_target(branch_target),
    .imem_req(imem_req), .pc_out(pc_out), .ir_load(ir_load), .exec_en(exec_en),
    .halted(halted), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] pc; logic ovf; logic unf;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: settles 2 time units after each negedge, then checks every fetch.
  always @(negedge clk) begin
    #2;
    if (ir_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fetch", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fetch_pc", pc_out, e.pc);
        chk("fetch_ovf", ras_ovf, e.ovf);
        chk("fetch_unf", ras_unf, e.unf);
      end
    end
  end

  // One instruction: fetch (ack after ackd cycles), EXEC stalled stl cycles, then commit.
  task automatic instr(input logic br, input logic cd, input logic cl, input logic rt,
                       input logic hl, input logic [4:0] tgt, input int ackd, input int stl,
                       input logic [4:0] epc, input logic eo, input logic eu);
    int n;
    exp_t e;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      chk("fetch_timeout", 0, 1);
      return;
    end
    e.pc = epc; e.ovf = eo; e.unf = eu;
    exp_q.push_back(e);
    imem_ack = 1'b0;
    for (int i = 0; i < ackd; i++) begin
      #2;
      chk("wait_imem_req", imem_req, 1);
      chk("wait_pc_hold", pc_out, epc);
      chk("wait_no_irload", ir_load, 0);
      @(negedge clk);
    end
    imem_ack = 1'b1;
    op_branch = br; cond = cd; op_call = cl; op_ret = rt; op_halt = hl;
    branch_target = tgt;
    stall = (stl > 0);
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < stl; i++) begin
      #2;
      chk("stall_exec_en", exec_en, 0);
      chk("stall_pc_hold", pc_out, epc);
      @(negedge clk);
    end
    stall = 1'b0;
    #2;
    chk("exec_en_pulse", exec_en, 1);
    @(negedge clk);
    op_branch = 0; cond = 0; op_call = 0; op_ret = 0; op_halt = 0;
  endtask

  task automatic noop(input logic [4:0] epc, input logic eo, input logic eu);
    instr(0, 0, 0, 0, 0, 5'd0, 0, 0, epc, eo, eu);
  endtask

  initial begin
    #12;
    chk("rst_pc", pc_out, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_ir_load", ir_load, 0);
    chk("rst_exec_en", exec_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", {ras_ovf, ras_unf}, 0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("idle_imem_req", imem_req, 0);
    @(negedge clk);

    // Free-running increment, wrapping 31 -> 0.
    for (int i = 0; i < 34; i++) noop(5'(i), 0, 0);
    noop(5'd2, 0, 0);
    // Not-taken branch at 3, then ack delay + stall at 4 with stray resume.
    instr(1, 0, 0, 0, 0, 5'd20, 0, 0, 5'd3, 0, 0);
    resume = 1'b1;
    instr(0, 0, 0, 0, 0, 5'd0, 3, 2, 5'd4, 0, 0);
    resume = 1'b0;
    instr(1, 1, 0, 0, 0, 5'd3, 0, 0, 5'd5, 0, 0);
    instr(1, 1, 0, 0, 0, 5'd20, 0, 0, 5'd3, 0, 0);
    // Call beats branch; return lands on 21.
    instr(1, 1, 1, 0, 0, 5'd9, 0, 1, 5'd20, 0, 0);
    instr(0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd9, 0, 0);
    instr(1, 1, 0, 0, 0, 5'd1, 0, 0, 5'd21, 0, 0);
    // Five nested calls into a 4-deep stack, then five returns.
    instr(0, 0, 1, 0, 0, 5'd2, 0, 0, 5'd1, 0, 0);
    instr(0, 0, 1, 0, 0, 5'd3, 0, 0, 5'd2, 0, 0);
    instr(0, 0, 1, 0, 0, 5'd4, 0, 0, 5'd3, 0, 0);
    instr(0, 0, 1, 0, 0, 5'd5, 0, 0, 5'd4, 0, 0);
    instr(0, 0, 1, 0, 0, 5'd6, 0, 0, 5'd5, 0, 0);
    instr(0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd6, 1, 0);
    instr(0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd5, 1, 0);
    instr(0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd4, 1, 0);
    instr(0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd3, 1, 0);
    instr(0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd2, 1, 0);
    instr(1, 1, 0, 0, 0, 5'd7, 0, 0, 5'd3, 1, 1);
    // Halt at 7, idle 10 cycles, resume at 8.
    instr(0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd7, 1, 1);
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("halt_halted", halted, 1);
      chk("halt_pc", pc_out, 8);
      chk("halt_no_req", {imem_req, ir_load, exec_en}, 0);
      @(negedge clk);
    end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    #2;
    chk("resume_halted", halted, 0);
    chk("resume_req", imem_req, 1);
    @(negedge clk);
    instr(1, 1, 0, 0, 0, 5'd12, 0, 0, 5'd8, 1, 1);
    // Reset while stalled in EXEC at 12 with a pending call.
    begin
      exp_t e;
      e.pc = 5'd12; e.ovf = 1; e.unf = 1;
      exp_q.push_back(e);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b1; op_call = 1'b1; branch_target = 5'd30;
    #2;
    chk("pre_rst_exec_en", exec_en, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_pc", pc_out, 0);
    chk("async_rst_flags", {ras_ovf, ras_unf, halted}, 0);
    chk("async_rst_strobes", {imem_req, ir_load, exec_en}, 0);
    @(negedge clk);
    stall = 1'b0; op_call = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    // Stack must be empty after reset: a return underflows.
    instr(0, 0, 0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    noop(5'd1, 0, 1);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PSIZE, default 5, width of program counter and all instruction addresses.
REQ-002 Parameter RAS_DEPTH, default 4, number of return-address stack entries (power of two, >=2).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_ack  input  1  program memory reports instruction word valid this cycle.
REQ-006 stall  input  1  datapath busy; current instruction not yet complete.
REQ-007 op_branch  input  1  decoded conditional/unconditional branch.
REQ-008 cond  input  1  branch condition true (unconditional branch drives 1).
REQ-009 op_call  input  1  decoded call to branch_target.
REQ-010 op_ret  input  1  decoded return via stack.
REQ-011 op_halt  input  1  decoded halt.
REQ-012 resume  input  1  leave HALT state.
REQ-013 branch_target  input  PSIZE  absolute target for branch and call.
REQ-014 imem_req  output  1  fetch request to program memory.
REQ-015 pc_out  output  PSIZE  current program counter; also program memory address.
REQ-016 ir_load  output  1  instruction register load strobe.
REQ-017 exec_en  output  1  datapath commit strobe for the current instruction.
REQ-018 halted  output  1  sequencer in HALT.
REQ-019 ras_ovf  output  1  sticky: call issued with stack full.
REQ-020 ras_unf  output  1  sticky: return issued with stack empty.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, EXEC, HALT; IDLE SHALL advance to FETCH unconditionally on the first clock edge after reset release.
REQ-022 In FETCH imem_req SHALL be 1; if imem_ack=1, ir_load SHALL be 1 in the same cycle and next state SHALL be EXEC; otherwise FETCH SHALL hold with pc_out unchanged, no timeout.
REQ-023 In EXEC with stall=1, exec_en SHALL be 0 and state, pc_out and stack SHALL be unchanged.
REQ-024 In EXEC with stall=0, exec_en SHALL be 1 for exactly that cycle and pc_out SHALL update at the following edge per the priority halt > ret > call > taken branch > increment.
REQ-025 halt: pc_out <= pc_out+1, next state HALT.
REQ-026 ret with stack non-empty: pc_out <= popped entry; with stack empty: pc_out <= pc_out+1 and ras_unf set.
REQ-027 call: pc_out <= branch_target and pc_out+1 pushed; with stack full the push SHALL be dropped, ras_ovf set, call still taken.
REQ-028 taken branch (op_branch=1 and cond=1): pc_out <= branch_target; op_branch=1 with cond=0 SHALL increment.
REQ-029 Non-halt EXEC completion SHALL return to FETCH; every instruction therefore costs at least 2 cycles (1 FETCH with immediate ack + 1 EXEC).
REQ-030 All pc_out arithmetic SHALL be modulo 2^PSIZE (all-ones +1 wraps to 0), including pushed return addresses.
REQ-031 Decode inputs SHALL be ignored outside EXEC and while stall=1.
REQ-032 In HALT halted SHALL be 1, imem_req 0; resume=1 SHALL move to FETCH at the held pc_out; resume outside HALT SHALL be ignored.
REQ-033 ir_load, exec_en and imem_req SHALL be 0 in IDLE and HALT.
REQ-034 ras_ovf and ras_unf SHALL remain set until reset.

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, pc_out 0, stack empty, ras_ovf 0, ras_unf 0, halted 0, imem_req 0, ir_load 0, exec_en 0, regardless of clk.
REQ-036 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the instruction with no exec_en pulse and no stack change.

Verification
REQ-037 Release reset, imem_ack=1 constant, no ops -> pc_out 0,1,2,... changing every 2 cycles, wraps 31->0 with PSIZE=5.
REQ-038 imem_ack held 0 for 3 cycles at pc 4 -> imem_req 1, pc_out 4 for 3 cycles, ir_load on 4th; stall=1 for 2 EXEC cycles -> exec_en delayed 2 cycles.
REQ-039 At pc 3: op_branch=1, cond=0 -> pc 4; op_branch=1, cond=1, target 20 -> pc 20; op_call and op_branch both 1, target 9 -> call wins, pc 9, 21 pushed.
REQ-040 Five nested calls from pc 1,2,3,4,5 with RAS_DEPTH=4 -> ras_ovf 1 after fifth; four rets return to 5,4,3,2; fifth ret -> pc+1, ras_unf 1.
REQ-041 op_halt at pc 7 -> halted 1, pc 8, no fetch for 10 cycles; resume -> FETCH at 8, halted 0.
REQ-042 reset pulsed low during EXEC with stall=1 at pc 12 -> pc_out 0 immediately, flags cleared, no exec_en.
